// File: rtl/x_mem_arb2_if.sv
// Bus bundle for x_mem_arb2: both master ports, the slave port and arbiter status.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface x_mem_arb2_if;
  logic        i_m0_valid;
  logic        i_m0_rnw;
  logic [31:0] i_m0_addr;
  logic [31:0] i_m0_data;
  logic        o_m0_accept;

  logic        i_m1_valid;
  logic        i_m1_rnw;
  logic [31:0] i_m1_addr;
  logic [31:0] i_m1_data;
  logic        i_m1_lock;
  logic        o_m1_accept;

  logic [31:0] o_m_data;

  logic        o_s_valid;
  logic        o_s_rnw;
  logic [31:0] o_s_addr;
  logic [31:0] o_s_data;
  logic        i_s_accept;
  logic [31:0] i_s_data;

  logic        o_owner;
  logic        o_err;

  modport slave (
    input  i_m0_valid, i_m0_rnw, i_m0_addr, i_m0_data,
    input  i_m1_valid, i_m1_rnw, i_m1_addr, i_m1_data, i_m1_lock,
    input  i_s_accept, i_s_data,
    output o_m0_accept, o_m1_accept, o_m_data,
    output o_s_valid, o_s_rnw, o_s_addr, o_s_data,
    output o_owner, o_err
  );

  modport master (
    output i_m0_valid, i_m0_rnw, i_m0_addr, i_m0_data,
    output i_m1_valid, i_m1_rnw, i_m1_addr, i_m1_data, i_m1_lock,
    output i_s_accept, i_s_data,
    input  o_m0_accept, o_m1_accept, o_m_data,
    input  o_s_valid, o_s_rnw, o_s_addr, o_s_data,
    input  o_owner, o_err
  );
endinterface

// File: rtl/x_mem_arb2.sv
// x_mem_arb2: round-robin two-master arbiter for the valid/accept memory bus, with m1 lock.
// Define X_MEM_ARB2_TIMEOUT_EN to build the slave-accept timeout (error reply + sticky o_err).
module x_mem_arb2 #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input logic         i_clk,
  input logic         i_rst,
  x_mem_arb2_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t state_q, state_d;
  logic   prio_q, prio_d;
  logic   owner_q, owner_d;
  logic   timeoutHit;

`ifdef X_MEM_ARB2_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] timeoutCnt_q, timeoutCnt_d;
  logic             err_q;

  // The counter holds the number of stalled grant cycles already spent, so the
  // TIMEOUT-th grant cycle is the one that answers on the slave's behalf.
  assign timeoutHit = (state_q != IDLE) && (timeoutCnt_q == CNT_W'(TIMEOUT - 1));
  assign bus.o_err  = err_q;

  always_comb begin
    timeoutCnt_d = '0;
    if ((state_q != IDLE) && !bus.i_s_accept && !timeoutHit) begin
      timeoutCnt_d = timeoutCnt_q + 1'b1;
    end
  end
`else
  logic unusedCfg;
  assign unusedCfg  = ^{ERR_DATA, TIMEOUT};
  assign timeoutHit = 1'b0;
  assign bus.o_err  = 1'b0;
`endif

  assign bus.o_owner = owner_q;

  // Slave request and master accepts come straight from the granted master so a
  // reset or dropped valid removes the request without waiting for a clock edge.
  always_comb begin
    bus.o_s_valid   = 1'b0;
    bus.o_s_rnw     = 1'b0;
    bus.o_s_addr    = '0;
    bus.o_s_data    = '0;
    bus.o_m0_accept = 1'b0;
    bus.o_m1_accept = 1'b0;
    bus.o_m_data    = bus.i_s_data;
    unique case (state_q)
      GNT0: begin
        bus.o_s_valid   = bus.i_m0_valid;
        bus.o_s_rnw     = bus.i_m0_rnw;
        bus.o_s_addr    = bus.i_m0_addr;
        bus.o_s_data    = bus.i_m0_data;
        bus.o_m0_accept = bus.i_s_accept;
      end
      GNT1: begin
        bus.o_s_valid   = bus.i_m1_valid;
        bus.o_s_rnw     = bus.i_m1_rnw;
        bus.o_s_addr    = bus.i_m1_addr;
        bus.o_s_data    = bus.i_m1_data;
        bus.o_m1_accept = bus.i_s_accept;
      end
      default: ;
    endcase
`ifdef X_MEM_ARB2_TIMEOUT_EN
    if (timeoutHit) begin
      bus.o_s_valid   = 1'b0;
      bus.o_m_data    = ERR_DATA;
      bus.o_m0_accept = (state_q == GNT0);
      bus.o_m1_accept = (state_q == GNT1);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_m0_valid && (!bus.i_m1_valid || !prio_q)) begin
          state_d = GNT0;
          owner_d = 1'b0;
        end else if (bus.i_m1_valid) begin
          state_d = GNT1;
          owner_d = 1'b1;
        end
      end
      GNT0: begin
        if (timeoutHit || bus.i_s_accept) begin
          state_d = IDLE;
          prio_d  = 1'b1;
        end else if (!bus.i_m0_valid) begin
          state_d = IDLE;
        end
      end
      GNT1: begin
        if (timeoutHit) begin
          state_d = IDLE;
          prio_d  = 1'b0;
        end else if (bus.i_s_accept) begin
          // A locked accept keeps m1 granted and leaves the pointer where it was.
          if (!bus.i_m1_lock) begin
            state_d = IDLE;
            prio_d  = 1'b0;
          end
        end else if (!bus.i_m1_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
`ifdef X_MEM_ARB2_TIMEOUT_EN
      timeoutCnt_q <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
`ifdef X_MEM_ARB2_TIMEOUT_EN
      timeoutCnt_q <= timeoutCnt_d;
      err_q        <= err_q | timeoutHit;
`endif
    end
  end
endmodule

// File: doc/x_mem_arb2.md
Name: x_mem_arb2

Overview:
- Two-requester arbiter for the single-port valid/accept memory bus used by the x_top_rv32i core.
- Master 0 is the core; master 1 is a secondary requester (debug loader / DMA).
- Grants the slave port to one master per transaction, using round-robin priority and an optional lock.
- Sits between the masters and the memory/peripheral decoder. Bus protocol is unchanged on every port.

Parameters:
- TIMEOUT, 255: cycles a granted transaction may wait for slave accept (used only with the optional feature).
- ERR_DATA, 32'hDEAD_BEEF: read data returned on timeout (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_m0_valid  in  1  master 0 request
- i_m0_rnw  in  1  master 0 read(1)/write(0)
- i_m0_addr  in  32  master 0 address
- i_m0_data  in  32  master 0 write data
- o_m0_accept  out  1  master 0 transaction complete
- i_m1_valid  in  1  master 1 request
- i_m1_rnw  in  1  master 1 read(1)/write(0)
- i_m1_addr  in  32  master 1 address
- i_m1_data  in  32  master 1 write data
- i_m1_lock  in  1  master 1 keeps the grant across back-to-back transactions
- o_m1_accept  out  1  master 1 transaction complete
- o_m_data  out  32  read data, broadcast to both masters
- o_s_valid  out  1  slave request
- o_s_rnw  out  1  slave read/write
- o_s_addr  out  32  slave address
- o_s_data  out  32  slave write data
- i_s_accept  in  1  slave completes the transaction; read data valid this cycle
- i_s_data  in  32  slave read data
- o_owner  out  1  current/last grant owner (0 or 1)
- o_err  out  1  sticky timeout flag (optional feature only, else tied 0)

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Protocol:
  - A master holds valid, rnw, addr and data stable until it sees accept.
  - Accept is a single-cycle pulse.
  - Read data is sampled in the accept cycle.
- States: IDLE, GNT0, GNT1.
- Reset values:
  - State IDLE; priority pointer prio=0 (master 0 preferred); o_owner=0; o_err=0.
  - All o_s_* = 0; both accepts = 0.
- IDLE:
  - No slave request is driven (o_s_valid=0).
  - Only one valid set: go to that master's GNT state.
  - Both valid: go to GNT<prio>.
  - One-cycle arbitration latency from valid to o_s_valid.
- GNTn:
  - o_s_valid/rnw/addr/data are driven combinationally from master n. o_owner=n.
  - o_mn_accept = i_s_accept. The other master's accept is 0.
  - o_m_data = i_s_data at all times.
- Completion: on i_s_accept in GNTn, set prio = ~n, then go to IDLE.
- Lock exception: in GNT1 with i_m1_lock=1 at accept, stay in GNT1 and leave prio unchanged. Master 0 is starved only while lock is held.
- Valid dropped while granted: if the granted master drops valid before accept (protocol violation), go to IDLE next cycle. o_s_valid follows the master's valid combinationally; no accept is issued.
- Simultaneous events:
  - i_s_accept and a new request from the other master in the same cycle: the new request is arbitrated in the following IDLE cycle.
  - Requests during GNT are held off with accept=0.
- Reset mid-transaction: immediately return to IDLE; o_s_valid drops asynchronously. The slave must tolerate an aborted request.
- Timeout counter: 8-bit minimum, width $clog2(TIMEOUT+1). Cleared in IDLE, incremented each GNT cycle without accept.

Optional Feature:
- Macro: X_MEM_ARB2_TIMEOUT_EN.
- Enabled:
  - When the counter reaches TIMEOUT in GNTn without i_s_accept, the arbiter itself pulses o_mn_accept for one cycle.
  - o_m_data=ERR_DATA for that cycle; o_s_valid is forced 0 that cycle.
  - o_err is set and stays set until reset. State goes to IDLE and prio=~n.
  - A late i_s_accept arriving while IDLE is ignored.
- Disabled: no counter is built; o_err tied 0; transactions wait indefinitely.

Test Plan:
- Single request: m0 read addr 0x100, slave accepts 2 cycles after o_s_valid with data 0x12345678 -> o_s_valid rises 1 cycle after i_m0_valid; o_m0_accept pulses once; o_m_data=0x12345678; o_m1_accept stays 0.
- Contention: both valid from reset, slave accepts every cycle -> grant order m0,m1,m0,m1; o_owner alternates; each transaction has 1 IDLE cycle between grants.
- Lock: m1 lock=1 for 3 writes while m0 is valid -> 3 consecutive m1 accepts with no IDLE gap; m0 is granted after lock drops; prio=1 is retained.
- Write mux: m1 write addr 0x2000 data 0xA5A5A5A5 -> o_s_rnw=0, o_s_addr=0x2000, o_s_data=0xA5A5A5A5 while GNT1.
- Reset during GNT0 with slave stalled -> o_s_valid=0 the same cycle; after reset, state is IDLE and prio=0.
- (X_MEM_ARB2_TIMEOUT_EN, TIMEOUT=4) slave never accepts m0 read -> o_m0_accept pulses on the 4th GNT cycle with o_m_data=0xDEADBEEF; o_err=1 sticky; m1 is granted next if valid.
